// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants plus helpers that derive totals and
// sync-window bounds from active/porch/sync widths.
package vga_timing_pkg;

  localparam int DEF_PIX_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int DEF_H_TOTAL      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with sync/active window decode.
// count/active/sync describe the value the counter takes after this clock.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_SYNC_START,
  parameter int SYNC_END   = DEF_H_SYNC_END,
  parameter bit POL        = 1'b0,
  parameter int W          = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  logic [W-1:0] cnt_q;
  logic [W:0]   cnt_x;

  assign wrap  = step && (cnt_q == W'(TOTAL - 1));
  assign count = !step ? cnt_q : (wrap ? '0 : cnt_q + 1'b1);

  // One extra bit so a window bound equal to 2**W does not truncate to zero.
  assign cnt_x  = {1'b0, count};
  assign active = cnt_x < (W+1)'(ACTIVE);
  assign sync   = ((cnt_x >= (W+1)'(SYNC_START)) && (cnt_x < (W+1)'(SYNC_END))) ? POL : ~POL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= count;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: clock-enable prescaler, horizontal and
// vertical axis counters, and a registered output stage with line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             h_sync,
  output logic             v_sync,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int PRE_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PIX_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, v_wrap, h_active, v_active, h_sync_nxt, v_sync_nxt;

  assign tick = en && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else if (en)   pre_cnt <= pre_cnt + 1'b1;
  end

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(sync_start(H_ACTIVE, H_FP)), .SYNC_END(sync_end(H_ACTIVE, H_FP, H_SYNC)),
    .POL(H_POL), .W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(tick),
    .count(h_count), .wrap(h_wrap), .active(h_active), .sync(h_sync_nxt)
  );

  // h_wrap already implies tick, so the vertical axis steps once per line.
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(sync_start(V_ACTIVE, V_FP)), .SYNC_END(sync_end(V_ACTIVE, V_FP, V_SYNC)),
    .POL(V_POL), .W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(h_wrap),
    .count(v_count), .wrap(v_wrap), .active(v_active), .sync(v_sync_nxt)
  );

  // Output stage: registers the post-edge counter view, so pix_tick lines up
  // with the first clock the new pixel_x is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (en) begin
        h_sync   <= h_sync_nxt;
        v_sync   <= v_sync_nxt;
        pixel_x  <= h_count;
        pixel_y  <= v_count;
        video_on <= h_active && v_active;
      end
    end
  end

endmodule
